// File: rtl/crypto_pkg.sv
// Shared types and constants for the crypto core result-dump path.
package crypto_pkg;

    // Dump sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    localparam int unsigned PH_W = 2;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex digit.
// Ports:
//   nib     - 4-bit value
//   ascii_c - ASCII character '0'..'9' / 'a'..'f'
module nibble_to_ascii
    import crypto_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii_c
);

    always_comb begin
        if (nib < 4'd10) begin
            ascii_c = ASCII_0 + 8'(nib);
        end else begin
            ascii_c = ASCII_A_LC + 8'(nib - 4'd10);
        end
    end

endmodule

// File: rtl/regdump_streamer.sv
// Walks the core register file after halt and streams it out as raw bytes
// or "%02h\n" ASCII lines over a valid/ready handshake.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   halted               - core halt level; starts a dump, re-arms when low
//   rf_addr / rf_data    - debug read port into the regfile (combinational data)
//   out_valid/out_ready  - byte stream handshake
//   out_data, out_last   - stream byte and final-byte marker
//   busy, done           - dump in progress / dump complete (held until halt drops)
module regdump_streamer
    import crypto_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned HEX_ASCII = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halted,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [PH_W-1:0]   LAST_PH  = (HEX_ASCII != 0) ? PH_W'(2) : PH_W'(0);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [7:0]        cap_q, cap_d;

    logic [7:0] hi_c, lo_c;
    logic [7:0] char_d;
    logic       out_valid_d, out_last_d, busy_d, done_d;

    // Characters are decoded from the next-cycle capture so out_data can be registered
    nibble_to_ascii u_hi (.nib(cap_d[7:4]), .ascii_c(hi_c));
    nibble_to_ascii u_lo (.nib(cap_d[3:0]), .ascii_c(lo_c));

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        cap_d   = cap_q;

        case (state_q)
            IDLE: begin
                if (halted) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    ph_d    = '0;
                end
            end
            LOAD: begin
                cap_d   = 8'(rf_data);
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (ph_q != LAST_PH) begin
                        ph_d = ph_q + PH_W'(1);
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        ph_d    = '0;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Return the read address to 0 while idle
                if (!halted) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ph_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        char_d = ASCII_NL;
        if (HEX_ASCII == 0) begin
            char_d = cap_d;
        end else begin
            case (ph_d)
                PH_W'(0): char_d = hi_c;
                PH_W'(1): char_d = lo_c;
                default:  char_d = ASCII_NL;
            endcase
        end

        out_valid_d = (state_d == SEND);
        out_last_d  = (state_d == SEND) && (idx_d == LAST_IDX) && (ph_d == LAST_PH);
        busy_d      = (state_d == LOAD) || (state_d == SEND);
        done_d      = (state_d == DONE);
        if (state_d != SEND) begin
            char_d = 8'h00;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ph_q      <= '0;
            cap_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ph_q      <= ph_d;
            cap_q     <= cap_d;
            out_valid <= out_valid_d;
            out_data  <= char_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign rf_addr = idx_q;

endmodule

// File: tb/tb_regdump_streamer.sv
module tb_regdump_streamer;

    logic clk = 1'b0;
    logic reset;
    logic out_ready;
    logic halted_h, halted_r;
    logic sel;

    logic [7:0] regs_h [16];
    logic [7:0] regs_r [16];

    logic [3:0] rf_addr_h, rf_addr_r;
    logic [7:0] rf_data_h, rf_data_r;
    logic       valid_h, valid_r, last_h, last_r, busy_h, busy_r, done_h, done_r;
    logic [7:0] data_h, data_r;

    logic       o_valid, o_last, o_busy, o_done;
    logic [7:0] o_data;
    logic [3:0] o_addr;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];

    always #5 clk = ~clk;

    assign rf_data_h = regs_h[rf_addr_h];
    assign rf_data_r = regs_r[rf_addr_r];

    regdump_streamer #(.NUM_REGS(16), .DATA_W(8), .ADDR_W(4), .HEX_ASCII(1)) dut_hex (
        .clk(clk), .reset(reset), .halted(halted_h),
        .rf_addr(rf_addr_h), .rf_data(rf_data_h),
        .out_valid(valid_h), .out_ready(out_ready), .out_data(data_h),
        .out_last(last_h), .busy(busy_h), .done(done_h)
    );

    regdump_streamer #(.NUM_REGS(16), .DATA_W(8), .ADDR_W(4), .HEX_ASCII(0)) dut_raw (
        .clk(clk), .reset(reset), .halted(halted_r),
        .rf_addr(rf_addr_r), .rf_data(rf_data_r),
        .out_valid(valid_r), .out_ready(out_ready), .out_data(data_r),
        .out_last(last_r), .busy(busy_r), .done(done_r)
    );

    assign o_valid = sel ? valid_r   : valid_h;
    assign o_data  = sel ? data_r    : data_h;
    assign o_last  = sel ? last_r    : last_h;
    assign o_busy  = sel ? busy_r    : busy_h;
    assign o_done  = sel ? done_r    : done_h;
    assign o_addr  = sel ? rf_addr_r : rf_addr_h;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] hc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    task automatic push_hex();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'b0, hc(regs_h[i][7:4])});
            exp_q.push_back({1'b0, hc(regs_h[i][3:0])});
            exp_q.push_back({(i == 15), 8'h0A});
        end
    endtask

    task automatic push_raw();
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), regs_r[i]});
    endtask

    // Drains the scoreboard through the selected instance; n = edges taken
    task automatic consume(input int ready_pct, output int n);
        logic       stalled;
        logic [7:0] hd;
        logic       hl;
        logic [8:0] e;
        n = 0;
        stalled = 1'b0;
        hd = 8'h00;
        hl = 1'b0;
        while (exp_q.size() > 0 && n < 2000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            if (o_valid && stalled) begin
                check("stall_data", 32'(o_data), 32'(hd));
                check("stall_last", 32'(o_last), 32'(hl));
            end
            if (o_valid && out_ready) begin
                e = exp_q.pop_front();
                check("byte", 32'(o_data), 32'(e[7:0]));
                check("last", 32'(o_last), 32'(e[8]));
                stalled = 1'b0;
            end else if (o_valid) begin
                stalled = 1'b1;
                hd = o_data;
                hl = o_last;
            end
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int  n;
        bit  found;
        reset     = 1'b1;
        out_ready = 1'b1;
        halted_h  = 1'b0;
        halted_r  = 1'b0;
        sel       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            regs_h[i] = 8'h10 + 8'(i);
            regs_r[i] = 8'h3C + 8'(i * 7);
        end
        regs_r[0] = 8'h00;
        regs_r[1] = 8'hFF;
        regs_r[2] = 8'hA5;
        repeat (3) tick();

        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_addr",  32'(o_addr),  32'd0);
        reset = 1'b0;
        tick();

        // Full ASCII dump with ready held high
        halted_h = 1'b1;
        tick();
        check("load_valid", 32'(o_valid), 32'd0);
        check("load_busy",  32'(o_busy),  32'd1);
        push_hex();
        consume(100, n);
        check("hex_cycles", 32'(n), 32'd64);
        check("hex_done",   32'(o_done), 32'd1);
        check("hex_busy",   32'(o_busy), 32'd0);

        // Halt held in DONE must not restart
        for (int i = 0; i < 10; i++) begin
            tick();
            check("done_hold_valid", 32'(o_valid), 32'd0);
        end
        check("done_hold", 32'(o_done), 32'd1);
        halted_h = 1'b0;
        tick();
        check("rearm_done", 32'(o_done), 32'd0);
        check("rearm_addr", 32'(o_addr), 32'd0);

        // Second dump: lowercase/boundary values, halt dropped mid-dump, stalls
        regs_h[3] = 8'h9C;
        regs_h[4] = 8'h0A;
        halted_h = 1'b1;
        tick();
        halted_h = 1'b0;
        push_hex();
        consume(40, n);
        check("stall_done", 32'(o_done), 32'd1);
        tick();
        check("stall_done_fall", 32'(o_done), 32'd0);

        // Reset mid-SEND at index 7 with halt high, then restart from index 0
        for (int i = 0; i < 16; i++) regs_h[i] = 8'h10 + 8'(i);
        halted_h = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            out_ready = 1'b1;
            if (o_valid && o_addr == 4'd7) found = 1'b1;
            else tick();
        end
        check("reach_idx7", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_addr",  32'(o_addr),  32'd0);
        check("rst_mid_busy",  32'(o_busy),  32'd0);
        tick();
        check("rst_wins_busy", 32'(o_busy), 32'd0);
        reset = 1'b0;
        tick();
        check("restart_busy", 32'(o_busy), 32'd1);
        push_hex();
        consume(100, n);
        check("restart_cycles", 32'(n), 32'd64);
        halted_h = 1'b0;
        tick();
        tick();

        // Raw byte dump
        sel = 1'b1;
        halted_r = 1'b1;
        tick();
        push_raw();
        consume(100, n);
        check("raw_cycles", 32'(n), 32'd32);
        check("raw_done",   32'(o_done), 32'd1);
        halted_r = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regdump_streamer.md
# regdump_streamer

Result-dump stage downstream of `cpu`. Once the core raises `halted`, it walks the 16-entry register file through a read-only debug port. It emits the contents as a byte stream over a valid/ready handshake, either as raw bytes or as ASCII hex lines (`"%02h\n"` format). The stream feeds the host UART/bridge that returns the encryption result.

## Interface

Parameters:
- `NUM_REGS`, 16, number of registers dumped (indices 0..NUM_REGS-1)
- `DATA_W`, 8, register width; must be 8
- `ADDR_W`, 4, regfile debug address width; `NUM_REGS` ≤ 2^ADDR_W
- `HEX_ASCII`, 1, 1 = three chars per register (hi nibble, lo nibble, 0x0A); 0 = one raw byte per register

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `halted` in 1: core halt flag, level
- `rf_addr` out ADDR_W: debug read address into regfile
- `rf_data` in DATA_W: combinational regfile read data for `rf_addr`
- `out_valid` out 1: byte available
- `out_ready` in 1: consumer accepts byte when `out_valid & out_ready` at a clock edge
- `out_data` out 8: stream byte
- `out_last` out 1: marks the final byte of the dump
- `busy` out 1: dump in progress (state ≠ IDLE, ≠ DONE)
- `done` out 1: dump complete, held until `halted` falls

## Operation

- States: IDLE, LOAD, SEND, DONE.
- IDLE → LOAD when `halted`=1. Register index `idx` ← 0 and char phase `ph` ← 0.
- LOAD: `rf_addr` = `idx`. Latch `rf_data` into `cap`, then go to SEND.
- SEND: `out_valid`=1 and `out_data` comes from `cap`/`ph`.
- SEND with `HEX_ASCII`=1:
  - ph0 = ASCII of `cap[7:4]`, ph1 = ASCII of `cap[3:0]`, ph2 = 8'h0A.
  - Nibble map: 0–9 → 8'h30–8'h39, A–F → lowercase 8'h61–8'h66.
- SEND with `HEX_ASCII`=0: one phase only; `out_data` = `cap`.
- Handshake in SEND:
  - Not on the last phase: `ph`++ and stay in SEND.
  - On the last phase with `idx` < NUM_REGS-1: `idx`++, `ph` ← 0, go to LOAD.
  - On the last phase with `idx` = NUM_REGS-1: go to DONE.
- `out_last` = 1 only in SEND, at `idx`=NUM_REGS-1 on the last phase.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- DONE: `done`=1. Go to IDLE when `halted`=0, which re-arms for the next run.
- `halted` falling during LOAD/SEND is ignored; the dump always completes.
- `rf_addr` = `idx` in all states (0 in IDLE). The regfile read has no side effects.
- Reset values: state IDLE, `idx`=0, `ph`=0, `cap`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, `rf_addr`=0.

## Timing

- `halted` sampled high at edge k: LOAD during k..k+1, and `out_valid` is high after edge k+1.
- With `out_ready` tied high, per register:
  - `HEX_ASCII`=1: 4 cycles (1 LOAD + 3 SEND); full dump 64 cycles.
  - `HEX_ASCII`=0: 2 cycles; full dump 32 cycles.
- `done` rises on the edge after the `out_last` handshake.
- `out_valid` never depends combinationally on `out_ready`. All outputs are registered or decoded from state/regs only.
- `reset` asserted in any state, including mid-SEND with `out_valid`=1, returns everything to reset values at that edge. A partial dump is dropped, not resumed.
- If `reset` and `halted` are both high, reset wins.
- `halted` still high after reset release starts a fresh dump from index 0.

## Structure

- Shared package `crypto_pkg`:
  - state enum `dump_state_t` {IDLE, LOAD, SEND, DONE}
  - constant `ASCII_NL` = 8'h0A
  - constants `ASCII_0` = 8'h30, `ASCII_A_LC` = 8'h61
- Sub-module `nibble_to_ascii`: combinational, 4-bit in / 8-bit out. Instantiated twice (hi and lo nibble).
- `cpu` exposes a second, read-only regfile port (`dbg_addr`/`dbg_data`) wired to `rf_addr`/`rf_data`.

## Test plan

- Reset, then load regs[i] = 8'h10+i, assert `halted`, `HEX_ASCII`=1, `out_ready`=1 → 48 bytes "10\n11\n…1f\n", `out_last` only on the final 8'h0A, `done`=1 at cycle 65 after `halted`.
- `HEX_ASCII`=0 with regs = {8'h00, 8'hFF, 8'hA5, …} → 16 raw bytes in index order; 32-cycle dump.
- `out_ready` toggling pseudo-randomly (≥50% low) → identical byte sequence; `out_data` and `out_last` stable while stalled.
- Register value 8'h9C → chars 8'h39, 8'h63, 8'h0A (lowercase check); 8'h0A → 8'h30, 8'h61, 8'h0A.
- `reset` pulsed during SEND at idx 7 with `halted` still high → `out_valid`=0 on the next edge, then a restart from "10\n".
- `halted` dropped mid-dump → dump completes. `halted` held high in DONE → no second dump. `halted` cycled low→high → second full dump.
